// File: rtl/fp_align_pipe.sv
// fp_align_pipe: FP-add exponent compare and significand align; FPALIGN_SUBNORMAL_EN keeps subnormals exact, else they flush to signed zero.
// Latency 2 cycles (S1 decode/compare, S2 shift into the output register), throughput 1 pair/cycle.
// Backpressure: in_ready drops only with both stages full and out_ready low; outputs hold until taken.
module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign_a,
  output logic                 out_sign_b,
  output logic [EXP_W-1:0]     out_exp,
  output logic [MAN_W:0]       out_man_a,
  output logic [MAN_W:0]       out_man_b,
  output logic                 out_guard,
  output logic                 out_round,
  output logic                 out_sticky,
  output logic [2:0]           out_class_a,
  output logic [2:0]           out_class_b,
  output logic                 out_ftz
);

  localparam int X    = MAN_W + 3;
  localparam int SH_W = $clog2(MAN_W + 4);
  localparam int CW   = ((EXP_W > SH_W) ? EXP_W : SH_W) + 1;

  localparam logic [2:0] CLS_ZERO = 3'd0;
`ifdef FPALIGN_SUBNORMAL_EN
  localparam logic [2:0] CLS_SUB  = 3'd1;
`endif
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_NAN  = 3'd4;

  typedef struct packed {
    logic         sign;
    logic [2:0]   cls;
    logic [X-1:0] ext;
  } opr_t;

  typedef struct packed {
    opr_t             opr;
    logic [EXP_W-1:0] eff;
    logic             ftz;
  } dec_t;

  function automatic dec_t decode(input logic [EXP_W+MAN_W:0] v);
    dec_t             o;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e           = v[EXP_W+MAN_W-1:MAN_W];
    f           = v[MAN_W-1:0];
    o.opr.sign  = v[EXP_W+MAN_W];
    o.opr.cls   = CLS_ZERO;
    o.opr.ext   = {1'b0, f, 2'b00};
    o.eff       = EXP_W'(1);
    o.ftz       = 1'b0;
    if (e == '0) begin
      if (f != '0) begin
`ifdef FPALIGN_SUBNORMAL_EN
        o.opr.cls = CLS_SUB;
`else
        o.opr.ext = '0;
        o.ftz     = 1'b1;
`endif
      end
    end else if (e == '1) begin
      o.opr.cls = (f == '0) ? CLS_INF : CLS_NAN;
      o.eff     = e;
    end else begin
      o.opr.cls = CLS_NORM;
      o.opr.ext = {1'b1, f, 2'b00};
      o.eff     = e;
    end
    return o;
  endfunction

  // ---------------- S1: classify, pick common exponent, saturated difference
  dec_t             dec_a, dec_b;
  logic [EXP_W-1:0] diff, exp_nxt;
  logic [SH_W-1:0]  d_nxt;
  logic             a_small_nxt, special, both_tiny;

  always_comb begin
    dec_a       = decode(in_a);
    dec_b       = decode(in_b);
    a_small_nxt = dec_a.eff < dec_b.eff;
    diff        = a_small_nxt ? (dec_b.eff - dec_a.eff) : (dec_a.eff - dec_b.eff);
    d_nxt       = (CW'(diff) > CW'(X)) ? SH_W'(X) : SH_W'(diff);
    exp_nxt     = a_small_nxt ? dec_b.eff : dec_a.eff;
    special     = (dec_a.opr.cls == CLS_INF) || (dec_a.opr.cls == CLS_NAN) ||
                  (dec_b.opr.cls == CLS_INF) || (dec_b.opr.cls == CLS_NAN);
    both_tiny   = (dec_a.opr.cls < CLS_NORM) && (dec_b.opr.cls < CLS_NORM);
    if (special) begin
      exp_nxt = '1;
      d_nxt   = '0;
    end else if (both_tiny) begin
      exp_nxt = '0;
      d_nxt   = '0;
    end
  end

  logic             s1_vld;
  opr_t             s1_a, s1_b;
  logic [EXP_W-1:0] s1_exp;
  logic [SH_W-1:0]  s1_d;
  logic             s1_a_small;
  logic             s1_ftz;
  logic             out_take;

  assign out_take = !out_valid || out_ready;
  assign in_ready = !s1_vld || out_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_exp     <= '0;
      s1_d       <= '0;
      s1_a_small <= 1'b0;
      s1_ftz     <= 1'b0;
    end else if (in_ready) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_a       <= dec_a.opr;
        s1_b       <= dec_b.opr;
        s1_exp     <= exp_nxt;
        s1_d       <= d_nxt;
        s1_a_small <= a_small_nxt;
        s1_ftz     <= dec_a.ftz | dec_b.ftz;
      end
    end
  end

  // ---------------- S2: shift the smaller operand; everything falling below round feeds sticky
  logic [X-1:0]   small_ext, shifted;
  logic [2*X-1:0] wide;
  logic           sticky_nxt;

  always_comb begin
    small_ext  = s1_a_small ? s1_a.ext : s1_b.ext;
    wide       = {small_ext, {X{1'b0}}} >> s1_d;
    shifted    = wide[2*X-1:X];
    sticky_nxt = |wide[X-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_sign_a  <= 1'b0;
      out_sign_b  <= 1'b0;
      out_exp     <= '0;
      out_man_a   <= '0;
      out_man_b   <= '0;
      out_guard   <= 1'b0;
      out_round   <= 1'b0;
      out_sticky  <= 1'b0;
      out_class_a <= '0;
      out_class_b <= '0;
      out_ftz     <= 1'b0;
    end else if (out_take) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_sign_a  <= s1_a.sign;
        out_sign_b  <= s1_b.sign;
        out_exp     <= s1_exp;
        out_man_a   <= s1_a_small ? shifted[X-1:2] : s1_a.ext[X-1:2];
        out_man_b   <= s1_a_small ? s1_b.ext[X-1:2] : shifted[X-1:2];
        out_guard   <= shifted[1];
        out_round   <= shifted[0];
        out_sticky  <= sticky_nxt;
        out_class_a <= s1_a.cls;
        out_class_b <= s1_b.cls;
        out_ftz     <= s1_ftz;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Bench for fp_align_pipe (binary32): directed table, backpressure/reset sequences, random stream vs value model.
`timescale 1ns/1ps
module tb_fp_align_pipe;
  localparam int EW   = 8;
  localparam int MW   = 23;
  localparam int MAXE = (1 << EW) - 1;
`ifdef FPALIGN_SUBNORMAL_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic        out_sign_a, out_sign_b, out_guard, out_round, out_sticky, out_ftz;
  logic [7:0]  out_exp;
  logic [23:0] out_man_a, out_man_b;
  logic [2:0]  out_class_a, out_class_b;

  always #5 clk = ~clk;

  fp_align_pipe #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign_a(out_sign_a), .out_sign_b(out_sign_b), .out_exp(out_exp),
    .out_man_a(out_man_a), .out_man_b(out_man_b),
    .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
    .out_class_a(out_class_a), .out_class_b(out_class_b), .out_ftz(out_ftz)
  );

  typedef struct packed {
    logic        sign_a, sign_b;
    logic [7:0]  exp;
    logic [23:0] man_a, man_b;
    logic        g, r, s;
    logic [2:0]  cls_a, cls_b;
    logic        ftz;
  } res_t;

  typedef struct packed {
    logic [31:0] a, b;
    res_t        want;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  function automatic res_t mk(input logic sa, input logic sb, input logic [7:0] e,
                              input logic [23:0] ma, input logic [23:0] mb,
                              input logic g, input logic r, input logic s,
                              input logic [2:0] ca, input logic [2:0] cb, input logic ftz);
    res_t x;
    x = '{sign_a: sa, sign_b: sb, exp: e, man_a: ma, man_b: mb, g: g, r: r, s: s,
          cls_a: ca, cls_b: cb, ftz: ftz};
    return x;
  endfunction

  function automatic res_t cur();
    return mk(out_sign_a, out_sign_b, out_exp, out_man_a, out_man_b, out_guard, out_round,
              out_sticky, out_class_a, out_class_b, out_ftz);
  endfunction

  task automatic cmp(input string tag, input res_t got, input res_t want);
    check({tag, ".sign_a"}, 32'(got.sign_a), 32'(want.sign_a));
    check({tag, ".sign_b"}, 32'(got.sign_b), 32'(want.sign_b));
    check({tag, ".exp"},    32'(got.exp),    32'(want.exp));
    check({tag, ".man_a"},  32'(got.man_a),  32'(want.man_a));
    check({tag, ".man_b"},  32'(got.man_b),  32'(want.man_b));
    check({tag, ".guard"},  32'(got.g),      32'(want.g));
    check({tag, ".round"},  32'(got.r),      32'(want.r));
    check({tag, ".sticky"}, 32'(got.s),      32'(want.s));
    check({tag, ".cls_a"},  32'(got.cls_a),  32'(want.cls_a));
    check({tag, ".cls_b"},  32'(got.cls_b),  32'(want.cls_b));
    check({tag, ".ftz"},    32'(got.ftz),    32'(want.ftz));
  endtask

  // Value-level reference: integer significands, alignment as division by 2^d.
  function automatic int cls_of(input int e, input longint f);
    if (e == 0) return (f == 0) ? 0 : (SUB_EN ? 1 : 0);
    if (e == MAXE) return (f == 0) ? 3 : 4;
    return 2;
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t   res;
    int     ea, eb, ca, cb, effa, effb, big_e, d;
    longint fa, fb, siga, sigb, small_sig, man_small, scaled, q, rm, den;
    bit     fla, flb, a_small, g, rr, s;
    ea = int'(a[30:23]);  eb = int'(b[30:23]);
    fa = longint'(a[22:0]); fb = longint'(b[22:0]);
    ca = cls_of(ea, fa);   cb = cls_of(eb, fb);
    fla = (ea == 0) && (fa != 0) && !SUB_EN;
    flb = (eb == 0) && (fb != 0) && !SUB_EN;
    siga = (ca == 2) ? ((longint'(1) << MW) + fa) : (fla ? 0 : fa);
    sigb = (cb == 2) ? ((longint'(1) << MW) + fb) : (flb ? 0 : fb);
    effa = (ea == 0) ? 1 : ea;
    effb = (eb == 0) ? 1 : eb;
    a_small = effa < effb;
    if (ca >= 3 || cb >= 3) begin
      big_e = MAXE; d = 0;
    end else if (ca < 2 && cb < 2) begin
      big_e = 0; d = 0;
    end else begin
      big_e = a_small ? effb : effa;
      d     = a_small ? (effb - effa) : (effa - effb);
    end
    small_sig = a_small ? siga : sigb;
    g = 1'b0; rr = 1'b0; s = 1'b0;
    if (d == 0) begin
      man_small = small_sig;
    end else if (d >= MW + 3) begin
      man_small = 0;
      s = (small_sig != 0);
    end else begin
      scaled    = small_sig * 4;
      den       = longint'(1) << d;
      q         = scaled / den;
      rm        = scaled % den;
      man_small = q / 4;
      g  = ((q / 2) % 2) != 0;
      rr = (q % 2) != 0;
      s  = (rm != 0);
    end
    res = mk(a[31], b[31], 8'(big_e),
             24'(a_small ? man_small : siga), 24'(a_small ? sigb : man_small),
             g, rr, s, 3'(ca), 3'(cb), fla || flb);
    return res;
  endfunction

  function automatic logic [31:0] rnd_op(input int base);
    int          e;
    logic [22:0] f;
    case ($urandom_range(0, 9))
      0:       e = 0;
      1:       e = MAXE;
      2, 3:    e = int'($urandom_range(0, MAXE));
      default: e = base + int'($urandom_range(0, 60)) - 30;
    endcase
    if (e < 0) e = 0;
    if (e > MAXE) e = MAXE;
    f = 23'($urandom);
    if ($urandom_range(0, 4) == 0) f = '0;
    return {1'($urandom), 8'(e), f};
  endfunction

  // One isolated pair through an idle pipe; also pins the 2-cycle latency.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, output res_t got);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("lat_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_cycle1_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_vld", 32'(out_valid), 32'd1);
    got = cur();
  endtask

  // mode 0: continuous input, out_ready low in cycles 3..5. mode 1: random valid/ready.
  task automatic stream(input int npairs, input int mode, input int budget);
    res_t        q[$];
    res_t        held, want;
    logic [31:0] pa, pb;
    bit          have, stalled;
    int          sent, recv, cyc, rdy_low, base;
    have = 0; stalled = 0; sent = 0; recv = 0; cyc = 0; rdy_low = 0;
    pa = '0; pb = '0; held = '0;
    while (recv < npairs && cyc < budget) begin
      @(negedge clk);
      if (!have && sent < npairs) begin
        base = int'($urandom_range(1, MAXE - 1));
        pa = rnd_op(base);
        pb = rnd_op(base);
        have = 1'b1;
      end
      in_a = pa; in_b = pb;
      in_valid  = have && (mode == 0 || $urandom_range(0, 3) != 0);
      out_ready = (mode == 0) ? !(cyc >= 3 && cyc <= 5) : ($urandom_range(0, 2) != 0);
      #1;
      if (stalled) begin
        check("stall_vld", 32'(out_valid), 32'd1);
        cmp("stall_hold", cur(), held);
      end
      check("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
      if (!in_ready) rdy_low++;
      if (out_valid && out_ready) begin
        check("pop_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          want = q.pop_front();
          cmp($sformatf("m%0d_out%0d", mode, recv), cur(), want);
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(pa, pb));
        sent++;
        have = 1'b0;
      end
      stalled = out_valid && !out_ready;
      held    = cur();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check($sformatf("m%0d_recv", mode), 32'(recv), 32'(npairs));
    if (mode == 0) check("bp_rdy_dropped", 32'(rdy_low > 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  localparam int NV = 13;
  vec_t vt[NV];
  res_t got;
  int   n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'h3F800000, 32'h3F800000, mk(0, 0, 8'h7F, 24'h800000, 24'h800000, 0, 0, 0, 2, 2, 0)};
    vt[1]  = '{32'h40000000, 32'h3F800001, mk(0, 0, 8'h80, 24'h800000, 24'h400000, 1, 0, 0, 2, 2, 0)};
    vt[2]  = '{32'h4E800000, 32'h3F800000, mk(0, 0, 8'h9D, 24'h800000, 24'h000000, 0, 0, 1, 2, 2, 0)};
    vt[3]  = '{32'h7F000000, 32'h00800001, mk(0, 0, 8'hFE, 24'h800000, 24'h000000, 0, 0, 1, 2, 2, 0)};
    vt[4]  = '{32'h7F800000, 32'h3F800000, mk(0, 0, 8'hFF, 24'h000000, 24'h800000, 0, 0, 0, 3, 2, 0)};
    vt[5]  = '{32'h7FC00000, 32'h3F800000, mk(0, 0, 8'hFF, 24'h400000, 24'h800000, 0, 0, 0, 4, 2, 0)};
`ifdef FPALIGN_SUBNORMAL_EN
    vt[6]  = '{32'h00400000, 32'h00800000, mk(0, 0, 8'h01, 24'h400000, 24'h800000, 0, 0, 0, 1, 2, 0)};
    vt[12] = '{32'h00000001, 32'h80400000, mk(0, 1, 8'h00, 24'h000001, 24'h400000, 0, 0, 0, 1, 1, 0)};
`else
    vt[6]  = '{32'h00400000, 32'h00800000, mk(0, 0, 8'h01, 24'h000000, 24'h800000, 0, 0, 0, 0, 2, 1)};
    vt[12] = '{32'h00000001, 32'h80400000, mk(0, 1, 8'h00, 24'h000000, 24'h000000, 0, 0, 0, 0, 0, 1)};
`endif
    vt[7]  = '{32'h80000000, 32'h00000000, mk(1, 0, 8'h00, 24'h000000, 24'h000000, 0, 0, 0, 0, 0, 0)};
    vt[8]  = '{32'h3F800007, 32'h41000000, mk(0, 0, 8'h82, 24'h100000, 24'h800000, 1, 1, 1, 2, 2, 0)};
    vt[9]  = '{32'h4C800000, 32'h3F800001, mk(0, 0, 8'h99, 24'h800000, 24'h000000, 0, 0, 1, 2, 2, 0)};
    vt[10] = '{32'h4C000000, 32'h3FC00000, mk(0, 0, 8'h98, 24'h800000, 24'h000000, 0, 1, 1, 2, 2, 0)};
    vt[11] = '{32'hBF800000, 32'h40400000, mk(1, 0, 8'h80, 24'h400000, 24'hC00000, 0, 0, 0, 2, 2, 0)};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    cmp("rst_data", cur(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      run_one(vt[i].a, vt[i].b, got);
      cmp($sformatf("vec%0d", i), got, vt[i].want);
    end

    stream(4, 0, 60);
    stream(400, 1, 6000);

    // Fill both stages with output stalled, then reset asynchronously.
    @(negedge clk);
    in_a = 32'h3F800000; in_b = 32'h40000000; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_a = 32'h40400000; in_b = 32'h3F800000;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_pre_vld", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_exp",   32'(out_exp),   32'd0);
    check("mid_rst_man_a",     32'(out_man_a), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy_after", 32'(in_ready),  32'd1);
    check("mid_rst_flush1",    32'(out_valid), 32'd0);
    @(negedge clk);
    check("mid_rst_flush2",    32'(out_valid), 32'd0);
    run_one(vt[0].a, vt[0].b, got);
    cmp("after_rst", got, vt[0].want);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
